// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// Opcode constants mirror memory_control so benches can derive dm_rw from an opcode.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [3:0] OP_ADR = 4'b1100;
   localparam logic [3:0] OP_LDR = 4'b1101;
   localparam logic [3:0] OP_STR = 4'b1110;

   // Only STR writes; LDR and ADR both read the RAM.
   function automatic logic op_rw(input logic [3:0] op);
      return (op == OP_STR) ? RW_WRITE : RW_READ;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Fetch port, data port and RAM port of the arbiter in one bundle.
// slave = arbiter side, master = requesters plus RAM read-data source.
interface mem_access_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;

   logic              dm_req;
   logic              dm_rw;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;

   logic              ram_en;
   logic              ram_rw;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, ram_rdata,
      output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
      output ram_en, ram_rw, ram_addr, ram_wdata, stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, ram_rdata,
      input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
      input  ram_en, ram_rw, ram_addr, ram_wdata, stall
   );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits; at_max forces the next grant to fetch.
// Latency: at_max follows inc by one edge; clr wins over inc; no backpressure.
module mem_arb_starve_ctr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   input  logic [W-1:0] max,
   output logic         at_max
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != max)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max = (cnt_q == max);

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one RAM between fetch and data ports: data first, fetch forced after STARVE_MAX data grants.
// Latency: gnt one cycle after req, valid RAM_LAT+1 cycles after req; requests wait (stall high) while busy.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RAM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   mem_access_arbiter_if.slave  bus
);

   localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam int SW    = $clog2(STARVE_MAX + 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_rw_q, ram_rw_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
   logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

   logic win_if, starve_inc, starve_clr, starve_at_max;

   mem_arb_starve_ctr #(.W(SW)) u_starve (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (starve_inc),
      .clr     (starve_clr),
      .max     (SW'(STARVE_MAX)),
      .at_max  (starve_at_max)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_cnt_d   = lat_cnt_q;
      ram_en_d    = ram_en_q;
      ram_rw_d    = ram_rw_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      starve_inc  = 1'b0;
      starve_clr  = ~bus.if_req;
      win_if      = bus.if_req & (~bus.dm_req | starve_at_max);

      unique case (state_q)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               state_d   = ACCESS;
               ram_en_d  = 1'b1;
               lat_cnt_d = '0;
               if (win_if) begin
                  owner_d     = OWN_IF;
                  ram_rw_d    = RW_READ;
                  ram_addr_d  = bus.if_addr;
                  ram_wdata_d = '0;
                  if_gnt_d    = 1'b1;
                  starve_clr  = 1'b1;
               end else begin
                  owner_d     = OWN_DM;
                  ram_rw_d    = bus.dm_rw;
                  ram_addr_d  = bus.dm_addr;
                  ram_wdata_d = bus.dm_wdata;
                  dm_gnt_d    = 1'b1;
                  starve_inc  = bus.if_req;
               end
            end
         end
         ACCESS: begin
            lat_cnt_d = lat_cnt_q + 1'b1;
            // Read data is only meaningful on the final enable cycle.
            if (lat_cnt_q == LAT_W'(RAM_LAT - 1)) begin
               state_d  = RESP;
               ram_en_d = 1'b0;
               if (owner_q == OWN_IF) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.ram_rdata;
               end else begin
                  dm_valid_d = 1'b1;
                  if (ram_rw_q == RW_READ) begin
                     dm_rdata_d = bus.ram_rdata;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         lat_cnt_q   <= '0;
         ram_en_q    <= 1'b0;
         ram_rw_q    <= RW_READ;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lat_cnt_q   <= lat_cnt_d;
         ram_en_q    <= ram_en_d;
         ram_rw_q    <= ram_rw_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.dm_gnt    = dm_gnt_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_rw    = ram_rw_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.stall     = (bus.if_req & ~if_valid_q) | (bus.dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench: dut0 uses RAM_LAT=1, dut1 uses RAM_LAT=3 for long-access and mid-access reset cases.
module tb_mem_access_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst0_n, rst1_n;
   always #5 clk = ~clk;

   mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
   mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

   mem_access_arbiter #(.RAM_LAT(1), .STARVE_MAX(4)) u_dut0 (
      .clk(clk), .reset_n(rst0_n), .bus(b0)
   );
   mem_access_arbiter #(.RAM_LAT(3), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .reset_n(rst1_n), .bus(b1)
   );

   typedef struct {
      owner_e      port;
      logic [31:0] rdata;
   } resp_t;

   resp_t  q0[$];
   resp_t  q1[$];
   owner_e gq0[$];
   int checks = 0;
   int failures = 0;
   int en_cycles, vcyc;
   logic found;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic push0(input owner_e p, input logic [31:0] d);
      resp_t r;
      r.port  = p;
      r.rdata = d;
      q0.push_back(r);
      gq0.push_back(p);
   endtask

   // dut0 response and grant monitor
   always @(negedge clk) begin
      resp_t  e;
      owner_e g;
      if (rst0_n && (b0.if_valid || b0.dm_valid)) begin
         if (q0.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut0 unexpected valid: if_valid=%b dm_valid=%b", b0.if_valid, b0.dm_valid);
         end else begin
            e = q0.pop_front();
            chk1("dut0 resp port is dm", b0.dm_valid, e.port == OWN_DM);
            chk32("dut0 resp rdata", b0.dm_valid ? b0.dm_rdata : b0.if_rdata, e.rdata);
         end
      end
      if (rst0_n && (b0.if_gnt || b0.dm_gnt)) begin
         if (gq0.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut0 unexpected grant: if_gnt=%b dm_gnt=%b", b0.if_gnt, b0.dm_gnt);
         end else begin
            g = gq0.pop_front();
            chk1("dut0 grant is dm", b0.dm_gnt, g == OWN_DM);
            chk1("dut0 single grant", b0.if_gnt & b0.dm_gnt, 1'b0);
         end
      end
   end

   // dut1 response monitor
   always @(negedge clk) begin
      resp_t e;
      if (rst1_n && (b1.if_valid || b1.dm_valid)) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut1 unexpected valid: if_valid=%b dm_valid=%b", b1.if_valid, b1.dm_valid);
         end else begin
            e = q1.pop_front();
            chk1("dut1 resp port is dm", b1.dm_valid, e.port == OWN_DM);
            chk32("dut1 resp rdata", b1.dm_valid ? b1.dm_rdata : b1.if_rdata, e.rdata);
         end
      end
   end

   // Acts as both dut0 requesters: holds req until valid, then re-requests or drops.
   task automatic serve(input int ndm, input int nif, input int raise_after);
      int dm_done = 0;
      int if_done = 0;
      int cyc = 0;
      b0.dm_req = (ndm > 0);
      b0.if_req = (nif > 0) && (raise_after == 0);
      while ((dm_done < ndm || if_done < nif) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (b0.dm_valid) begin
            dm_done++;
            b0.dm_addr = b0.dm_addr + 32'd4;
            if (dm_done == ndm) b0.dm_req = 1'b0;
            if (dm_done == raise_after && nif > 0) b0.if_req = 1'b1;
         end
         if (b0.if_valid) begin
            if_done++;
            b0.if_addr = b0.if_addr + 32'd4;
            if (if_done == nif) b0.if_req = 1'b0;
         end
      end
      chk1("serve completed in budget", cyc < 300, 1'b1);
   endtask

   initial begin
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      b0.if_req = 1'b0; b0.if_addr = '0; b0.dm_req = 1'b0; b0.dm_rw = RW_READ;
      b0.dm_addr = '0; b0.dm_wdata = '0; b0.ram_rdata = '0;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_rw = RW_READ;
      b1.dm_addr = '0; b1.dm_wdata = '0; b1.ram_rdata = '0;

      // Reset with both requests high
      b0.if_req = 1'b1; b0.dm_req = 1'b1; b0.if_addr = 32'h4; b0.ram_rdata = 32'h0000_1234;
      repeat (2) @(negedge clk);
      chk1("rst if_gnt", b0.if_gnt, 1'b0);
      chk1("rst dm_gnt", b0.dm_gnt, 1'b0);
      chk1("rst if_valid", b0.if_valid, 1'b0);
      chk1("rst dm_valid", b0.dm_valid, 1'b0);
      chk1("rst ram_en", b0.ram_en, 1'b0);
      chk1("rst ram_rw", b0.ram_rw, 1'b1);
      chk32("rst ram_addr", b0.ram_addr, 32'h0);
      chk1("rst stall", b0.stall, 1'b1);
      chk1("rst dut1 ram_en", b1.ram_en, 1'b0);
      push0(OWN_DM, 32'h0000_1234);
      push0(OWN_IF, 32'h0000_1234);
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      @(negedge clk);
      chk1("release dm_gnt first edge", b0.dm_gnt, 1'b1);
      serve(1, 1, 0);
      repeat (2) @(negedge clk);
      chk1("idle stall", b0.stall, 1'b0);

      // Fetch-only read
      b0.ram_rdata = 32'hDEAD_BEEF;
      b0.if_addr = 32'h10;
      b0.if_req = 1'b1;
      push0(OWN_IF, 32'hDEAD_BEEF);
      #1 chk1("fetch stall pending", b0.stall, 1'b1);
      @(negedge clk);
      chk1("fetch if_gnt cycle1", b0.if_gnt, 1'b1);
      chk1("fetch ram_en", b0.ram_en, 1'b1);
      chk1("fetch ram_rw", b0.ram_rw, 1'b1);
      chk32("fetch ram_addr", b0.ram_addr, 32'h10);
      chk32("fetch ram_wdata", b0.ram_wdata, 32'h0);
      @(negedge clk);
      chk1("fetch if_valid cycle2", b0.if_valid, 1'b1);
      chk32("fetch if_rdata", b0.if_rdata, 32'hDEAD_BEEF);
      chk1("fetch stall at valid", b0.stall, 1'b0);
      chk1("fetch ram_en off", b0.ram_en, 1'b0);
      b0.if_req = 1'b0;
      @(negedge clk);
      chk1("fetch if_valid pulse", b0.if_valid, 1'b0);

      // STR write: dm_rdata keeps the earlier read value
      b0.dm_rw = op_rw(OP_STR);
      b0.dm_addr = 32'h20;
      b0.dm_wdata = 32'h55;
      b0.dm_req = 1'b1;
      push0(OWN_DM, 32'h0000_1234);
      @(negedge clk);
      chk1("str dm_gnt", b0.dm_gnt, 1'b1);
      chk1("str ram_en", b0.ram_en, 1'b1);
      chk1("str ram_rw", b0.ram_rw, 1'b0);
      chk32("str ram_addr", b0.ram_addr, 32'h20);
      chk32("str ram_wdata", b0.ram_wdata, 32'h55);
      @(negedge clk);
      chk1("str dm_valid", b0.dm_valid, 1'b1);
      chk1("str ram_en off", b0.ram_en, 1'b0);
      b0.dm_req = 1'b0;
      @(negedge clk);
      chk1("str dm_valid pulse", b0.dm_valid, 1'b0);
      chk32("str dm_rdata held", b0.dm_rdata, 32'h0000_1234);

      // Starvation: 3 dm grants with fetch idle, then both held continuously
      b0.dm_rw = op_rw(OP_LDR);
      b0.dm_addr = 32'h100;
      b0.if_addr = 32'h200;
      b0.ram_rdata = 32'hCAFE_0000;
      for (int i = 0; i < 7; i++) push0(OWN_DM, 32'hCAFE_0000);
      push0(OWN_IF, 32'hCAFE_0000);
      for (int i = 0; i < 4; i++) push0(OWN_DM, 32'hCAFE_0000);
      push0(OWN_IF, 32'hCAFE_0000);
      push0(OWN_DM, 32'hCAFE_0000);
      serve(12, 2, 3);
      repeat (2) @(negedge clk);

      // RAM_LAT=3 read: ram_rdata changes every enable cycle
      b1.dm_rw = op_rw(OP_ADR);
      b1.dm_addr = 32'h40;
      b1.dm_req = 1'b1;
      q1.push_back('{OWN_DM, 32'hA000_0003});
      en_cycles = 0;
      vcyc = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (b1.ram_en) begin
            en_cycles++;
            b1.ram_rdata = 32'hA000_0000 + en_cycles;
         end
         if (b1.dm_valid) begin
            vcyc = c;
            b1.dm_req = 1'b0;
         end
      end
      chk32("lat3 ram_en cycles", en_cycles, 32'd3);
      chk32("lat3 valid cycle", vcyc, 32'd4);

      // Reset in the middle of a RAM_LAT=3 access
      b1.dm_addr = 32'h44;
      b1.ram_rdata = 32'hB0B0_B0B0;
      b1.dm_req = 1'b1;
      @(negedge clk);
      chk1("midrst dm_gnt", b1.dm_gnt, 1'b1);
      @(negedge clk);
      chk1("midrst ram_en before", b1.ram_en, 1'b1);
      rst1_n = 1'b0;
      #1 chk1("midrst ram_en async", b1.ram_en, 1'b0);
      chk1("midrst stall", b1.stall, 1'b1);
      repeat (3) @(negedge clk);
      chk1("midrst no valid", b1.dm_valid, 1'b0);
      q1.push_back('{OWN_DM, 32'hB0B0_B0B0});
      rst1_n = 1'b1;
      @(negedge clk);
      chk1("midrst regrant", b1.dm_gnt, 1'b1);
      chk32("midrst regrant addr", b1.ram_addr, 32'h44);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         @(negedge clk);
         if (b1.dm_valid) begin
            found = 1'b1;
            b1.dm_req = 1'b0;
         end
      end
      chk1("midrst completes", found, 1'b1);

      repeat (3) @(negedge clk);
      chk32("dut0 resp queue drained", q0.size(), 32'd0);
      chk32("dut0 grant queue drained", gq0.size(), 32'd0);
      chk32("dut1 resp queue drained", q1.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
